// File: rtl/lorenz_step_ctrl.sv
// lorenz_step_ctrl
//   Sequencer for the 7.20 fixed-point Lorenz DDA. It holds the integrators in
//   their initial condition while idle, paces integration steps with a
//   programmable divider (run / pause / single-step), and captures every new
//   x/y/z state into a valid/ready sample port. Integration stalls while the
//   sample port is full.
//
// Ports
//   clock, reset             system clock, asynchronous active-low reset
//   cmd_start/pause/resume/single/load   one-cycle command pulses
//   divider                  step period minus 1 (0 behaves as 1)
//   max_steps                step limit, 0 = unlimited
//   dda_x/y/z                current integrator outputs
//   dda_load                 integrator initial-condition load (active high)
//   dda_en                   integrator step enable, one pulse per step
//   smp_x/y/z, smp_valid, smp_ready   captured-state sample port
//   step_count               steps captured since start
//   state, done              IDLE=0 RUN=1 PAUSE=2 DONE=3, done high in DONE
module lorenz_step_ctrl #(
   parameter int WIDTH = 27,
   parameter int DIV_W = 16,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_start,
   input  logic             cmd_pause,
   input  logic             cmd_resume,
   input  logic             cmd_single,
   input  logic             cmd_load,
   input  logic [DIV_W-1:0] divider,
   input  logic [CNT_W-1:0] max_steps,
   input  logic [WIDTH-1:0] dda_x,
   input  logic [WIDTH-1:0] dda_y,
   input  logic [WIDTH-1:0] dda_z,
   output logic             dda_load,
   output logic             dda_en,
   output logic [WIDTH-1:0] smp_x,
   output logic [WIDTH-1:0] smp_y,
   output logic [WIDTH-1:0] smp_z,
   output logic             smp_valid,
   input  logic             smp_ready,
   output logic [CNT_W-1:0] step_count,
   output logic [2:0]       state,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_DONE  = 3'd3
   } state_t;

   state_t           st, st_nxt;
   logic [DIV_W-1:0] div_cnt, div_term;
   logic             cap;          // step issued last cycle, capture now
   logic             single_pend;  // single-step requested while paused
   logic             restart;      // DONE->IDLE via cmd_start, go to RUN next
   logic             tick, port_free, hit;
   logic [CNT_W-1:0] count_inc;

   // A step needs one cycle to integrate and one to capture, so the shortest
   // usable period is 2 clocks.
   assign div_term  = (divider == '0) ? DIV_W'(1) : divider;
   // >= rather than == so a divider lowered below the running count ticks
   // immediately instead of wrapping the counter.
   assign tick      = (div_cnt >= div_term);
   assign port_free = !cap && (!smp_valid || smp_ready);
   assign count_inc = step_count + 1'b1;
   assign hit       = cap && (max_steps != '0) && (count_inc == max_steps);

   assign dda_load = (st == S_IDLE);
   assign done     = (st == S_DONE);
   assign state    = st;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) st <= S_IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      dda_en = 1'b0;
      case (st)
         S_IDLE:  if (cmd_start || restart) st_nxt = S_RUN;
         S_RUN: begin
            if (cmd_pause) st_nxt = S_PAUSE;
            else           dda_en = tick && port_free;
         end
         S_PAUSE: begin
            if (cmd_resume) st_nxt = S_RUN;
            dda_en = single_pend && port_free;
         end
         S_DONE:  if (cmd_start) st_nxt = S_IDLE;
         default: st_nxt = S_IDLE;
      endcase
      // The step limit outranks a same-cycle pause; load outranks everything.
      if (hit && (st == S_RUN || st == S_PAUSE)) st_nxt = S_DONE;
      if (cmd_load) begin
         st_nxt = S_IDLE;
         dda_en = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_cnt     <= '0;
         cap         <= 1'b0;
         single_pend <= 1'b0;
         restart     <= 1'b0;
         smp_valid   <= 1'b0;
         smp_x       <= '0;
         smp_y       <= '0;
         smp_z       <= '0;
         step_count  <= '0;
      end else begin
         cap     <= dda_en;
         restart <= (st == S_DONE) && cmd_start && !cmd_load;

         // Capture wins over acceptance so a sample arriving in the same
         // cycle as the handshake keeps smp_valid high.
         if (cap) begin
            smp_x      <= dda_x;
            smp_y      <= dda_y;
            smp_z      <= dda_z;
            smp_valid  <= 1'b1;
            step_count <= count_inc;
         end else if (smp_ready) begin
            smp_valid  <= 1'b0;
         end

         if (st == S_IDLE && st_nxt == S_RUN) step_count <= '0;

         // Counter only runs while staying in RUN; any entry restarts at 0.
         if (st == S_RUN && st_nxt == S_RUN) begin
            if (dda_en)     div_cnt <= '0;
            else if (!tick) div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
         end

         if (st != S_PAUSE || st_nxt != S_PAUSE) single_pend <= 1'b0;
         else if (dda_en)                        single_pend <= 1'b0;
         else if (cmd_single)                    single_pend <= 1'b1;

         if (cmd_load) begin
            smp_valid  <= 1'b0;
            cap        <= 1'b0;
            step_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lorenz_step_ctrl.sv
// Bench for lorenz_step_ctrl: a behavioural Lorenz integrator stands in for the
// DDA, a cycle model of the sequencer predicts every output on every cycle,
// and directed scenarios pin the model with hand-computed values before a
// randomized command/backpressure run.
module tb_lorenz_step_ctrl;
   localparam int WIDTH = 27;
   localparam longint ONE = 64'sd1 << 20;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              cmd_start = 0, cmd_pause = 0, cmd_resume = 0, cmd_single = 0, cmd_load = 0;
   logic [15:0]       divider = 16'd3;
   logic [31:0]       max_steps = 32'd0;
   logic [WIDTH-1:0]  dda_x, dda_y, dda_z;
   logic              dda_load, dda_en;
   logic [WIDTH-1:0]  smp_x, smp_y, smp_z;
   logic              smp_valid;
   logic              smp_ready = 1'b1;
   logic [31:0]       step_count;
   logic [2:0]        state;
   logic              done;

   int n_chk = 0, n_pass = 0, en_cnt = 0;

   lorenz_step_ctrl dut (
      .clock(clock), .reset(reset),
      .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_resume(cmd_resume),
      .cmd_single(cmd_single), .cmd_load(cmd_load),
      .divider(divider), .max_steps(max_steps),
      .dda_x(dda_x), .dda_y(dda_y), .dda_z(dda_z),
      .dda_load(dda_load), .dda_en(dda_en),
      .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z),
      .smp_valid(smp_valid), .smp_ready(smp_ready),
      .step_count(step_count), .state(state), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Lorenz integrator, sigma=10 rho=28 beta=8/3, dt=1/256, 7.20 fixed point.
   longint ix, iy, iz;
   always @(posedge clock or negedge reset) begin
      if (!reset || dda_load) begin
         ix <= -ONE; iy <= 2 * ONE; iz <= 0;
      end else if (dda_en) begin
         ix <= ix + ((10 * (iy - ix)) >>> 8);
         iy <= iy + ((((ix * (28 * ONE - iz)) >>> 20) - iy) >>> 8);
         iz <= iz + ((((ix * iy) >>> 20) - (8 * iz) / 3) >>> 8);
      end
   end
   assign dda_x = WIDTH'(ix);
   assign dda_y = WIDTH'(iy);
   assign dda_z = WIDTH'(iz);

   // Sequencer model: state 0..3, cycles elapsed since the last step (el),
   // step-in-flight flag, sample register and step counter.
   int               m_state, m_el, term, nst;
   bit               m_cap, m_valid, m_single, m_restart, free, e_en, hit;
   logic [WIDTH-1:0] m_sx, m_sy, m_sz;
   logic [31:0]      m_cnt;

   always @(negedge clock) begin
      if (!reset) begin
         m_state = 0; m_el = 0; m_cap = 0; m_valid = 0; m_single = 0; m_restart = 0;
         m_sx = '0; m_sy = '0; m_sz = '0; m_cnt = '0;
         chk("rst_state", 64'(state), 64'd0);
         chk("rst_dda_load", 64'(dda_load), 64'd1);
         chk("rst_dda_en", 64'(dda_en), 64'd0);
         chk("rst_smp_valid", 64'(smp_valid), 64'd0);
         chk("rst_step_count", 64'(step_count), 64'd0);
         chk("rst_done", 64'(done), 64'd0);
      end else begin
         term = (divider == 0) ? 1 : int'(divider);
         free = !m_cap && (!m_valid || smp_ready);
         e_en = 0;
         if (m_state == 1)      e_en = (m_el >= term) && free && !cmd_load && !cmd_pause;
         else if (m_state == 2) e_en = m_single && free && !cmd_load;

         chk("state", 64'(state), 64'(m_state));
         chk("dda_en", 64'(dda_en), 64'(e_en));
         chk("dda_load", 64'(dda_load), 64'(m_state == 0));
         chk("done", 64'(done), 64'(m_state == 3));
         chk("smp_valid", 64'(smp_valid), 64'(m_valid));
         chk("step_count", 64'(step_count), 64'(m_cnt));
         chk("smp_x", 64'(smp_x), 64'(m_sx));
         chk("smp_y", 64'(smp_y), 64'(m_sy));
         chk("smp_z", 64'(smp_z), 64'(m_sz));
         if (dda_en) en_cnt++;

         hit = 0;
         if (m_cap) begin
            m_sx = WIDTH'(ix); m_sy = WIDTH'(iy); m_sz = WIDTH'(iz);
            m_valid = 1;
            m_cnt = m_cnt + 1;
            hit = (max_steps != 0) && (m_cnt == max_steps);
         end else if (m_valid && smp_ready) begin
            m_valid = 0;
         end
         nst = m_state;
         case (m_state)
            0: if (cmd_start || m_restart) begin nst = 1; m_el = 0; m_cnt = 0; end
            1: begin
               if (cmd_pause)       begin nst = 2; m_el = 0; end
               else if (e_en)       m_el = 0;
               else if (m_el < term) m_el++;
            end
            2: begin
               if (cmd_resume) begin nst = 1; m_el = 0; end
               if (e_en)            m_single = 0;
               else if (cmd_single) m_single = 1;
            end
            default: if (cmd_start) nst = 0;
         endcase
         m_restart = (m_state == 3) && cmd_start && !cmd_load;
         if (hit && (m_state == 1 || m_state == 2)) nst = 3;
         if (cmd_load) begin nst = 0; m_valid = 0; m_cnt = 0; m_el = 0; end
         if (nst != 2) m_single = 0;
         m_cap = e_en;
         m_state = nst;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic restart_run();
      cmd_load = 1; cyc(1); cmd_load = 0;
      cmd_start = 1; cyc(1); cmd_start = 0;
   endtask

   logic [WIDTH-1:0] x_step1;

   initial begin
      x_step1 = WIDTH'(-925696);  // -1.0 + 30/256 in 7.20
      cyc(3);
      chk("reset_load", 64'(dda_load), 64'd1);
      chk("reset_state", 64'(state), 64'd0);

      // 1: divider=3, period 4, first sample two cycles after the step
      reset = 1; cmd_start = 1; cyc(1); cmd_start = 0;
      en_cnt = 0;
      cyc(5);
      chk("t1_first_valid", 64'(smp_valid), 64'd1);
      chk("t1_first_x", 64'(smp_x), 64'(x_step1));
      chk("t1_first_count", 64'(step_count), 64'd1);
      cyc(35);
      chk("t1_en_pulses", 64'(en_cnt), 64'd10);
      chk("t1_count", 64'(step_count), 64'd9);

      // 2: divider=0 steps every 2 cycles
      divider = 0; restart_run(); en_cnt = 0;
      cyc(20);
      chk("t2_en_pulses", 64'(en_cnt), 64'd10);

      // 3: backpressure holds the second step until the sample is taken
      divider = 3; smp_ready = 0; restart_run(); en_cnt = 0;
      cyc(20);
      chk("t3_en_blocked", 64'(en_cnt), 64'd1);
      chk("t3_count", 64'(step_count), 64'd1);
      chk("t3_valid_held", 64'(smp_valid), 64'd1);
      smp_ready = 1; cyc(1);
      chk("t3_en_on_ready", 64'(en_cnt), 64'd2);
      chk("t3_valid_gap", 64'(smp_valid), 64'd0);
      cyc(1);
      chk("t3_next_valid", 64'(smp_valid), 64'd1);
      chk("t3_next_count", 64'(step_count), 64'd2);

      // 4: step limit
      max_steps = 5; divider = 1; restart_run(); en_cnt = 0;
      cyc(100);
      chk("t4_en_pulses", 64'(en_cnt), 64'd5);
      chk("t4_state", 64'(state), 64'd3);
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_count", 64'(step_count), 64'd5);

      // 5: pause, three single steps, resume
      max_steps = 0; divider = 3; restart_run();
      cyc(10);
      cmd_pause = 1; cyc(1); cmd_pause = 0;
      en_cnt = 0;
      repeat (3) begin
         cmd_single = 1; cyc(1); cmd_single = 0; cyc(9);
      end
      chk("t5_single_pulses", 64'(en_cnt), 64'd3);
      chk("t5_count", 64'(step_count), 64'd5);
      chk("t5_state", 64'(state), 64'd2);
      cmd_resume = 1; cyc(1); cmd_resume = 0; en_cnt = 0;
      cyc(20);
      chk("t5_resume_pulses", 64'(en_cnt), 64'd5);

      // 6: load beats pause; asynchronous reset mid-run
      smp_ready = 0; cyc(8);
      chk("t6_valid_before", 64'(smp_valid), 64'd1);
      cmd_load = 1; cmd_pause = 1; cyc(1); cmd_load = 0; cmd_pause = 0;
      chk("t6_state", 64'(state), 64'd0);
      chk("t6_valid", 64'(smp_valid), 64'd0);
      chk("t6_load", 64'(dda_load), 64'd1);
      chk("t6_count", 64'(step_count), 64'd0);
      smp_ready = 1; cmd_start = 1; cyc(1); cmd_start = 0; cyc(10);
      @(posedge clock); #3;
      reset = 0; #1;
      chk("t6_async_state", 64'(state), 64'd0);
      chk("t6_async_load", 64'(dda_load), 64'd1);
      chk("t6_async_en", 64'(dda_en), 64'd0);
      chk("t6_async_valid", 64'(smp_valid), 64'd0);
      chk("t6_async_count", 64'(step_count), 64'd0);
      chk("t6_async_smp_x", 64'(smp_x), 64'd0);
      chk("t6_async_done", 64'(done), 64'd0);
      cyc(2);
      reset = 1;

      // randomized commands, backpressure, divider and limit
      for (int i = 0; i < 2500; i++) begin
         smp_ready  = ($urandom_range(0, 3) != 0);
         cmd_load   = ($urandom_range(0, 199) == 0);
         cmd_pause  = ($urandom_range(0, 39) == 0);
         cmd_resume = ($urandom_range(0, 29) == 0);
         cmd_single = ($urandom_range(0, 9) == 0);
         cmd_start  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 99) == 0) divider = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 149) == 0)
            max_steps = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(2, 15)) : 32'd0;
         cyc(1);
      end
      cmd_load = 0; cmd_pause = 0; cmd_resume = 0; cmd_single = 0; cmd_start = 0;
      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/lorenz_step_ctrl.md
Name: lorenz_step_ctrl

Overview:
Sequencer for the 7.20 fixed-point Lorenz DDA: the three integrators plus the dx/dy/dz function units. Responsibilities:
- Drives the DDA initial-condition load and the per-step integrator clock-enable.
- Paces steps with a programmable divider and supports run, pause and single-step.
- Captures each new x/y/z state into a valid/ready sample port for the display/HPS consumer, stalling integration under backpressure.

Parameters:
WIDTH, 27, state-variable width (7.20 two's complement)
DIV_W, 16, width of step-rate divider
CNT_W, 32, width of step counter and step limit

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle pulse: begin integrating from initial conditions
cmd_pause  in  1  one-cycle pulse: stop stepping, hold state
cmd_resume  in  1  one-cycle pulse: leave PAUSE
cmd_single  in  1  one-cycle pulse: one step while paused
cmd_load  in  1  one-cycle pulse: abort, reload initial conditions
divider  in  DIV_W  step period minus 1, in clocks
max_steps  in  CNT_W  step limit; 0 = unlimited
dda_x, dda_y, dda_z  in  WIDTH  current integrator outputs
dda_load  out  1  integrator load (drives DDA reset input, active-high)
dda_en  out  1  integrator clock-enable, one-cycle pulse per step
smp_x, smp_y, smp_z  out  WIDTH  captured state
smp_valid  out  1  sample available
smp_ready  in  1  consumer accepts sample
step_count  out  CNT_W  steps completed since start
state  out  3  IDLE=0, RUN=1, PAUSE=2, DONE=3
done  out  1  high in DONE

Behaviour:
- Reset (reset low, async):
  - state=IDLE, dda_load=1, dda_en=0, smp_valid=0, smp_x/y/z=0, step_count=0, done=0.
  - Divider counter=0, capture-pending flag cap=0.
- IDLE:
  - dda_load=1 continuously, so integrators hold initial values.
  - cmd_start → RUN: step_count=0, divider counter=0, dda_load=0 from next cycle.
- RUN:
  - Divider counter increments each cycle; tick when counter==max(divider,1).
  - dda_en=1 for one cycle iff tick && cap==0 && (smp_valid==0 || smp_ready==1); counter then returns to 0.
  - Tick but blocked: counter holds at terminal value; dda_en fires on the first unblocked cycle.
- Capture timing:
  - Cycle after dda_en (cap=1): dda_x/y/z registered into smp_x/y/z, smp_valid=1, step_count+1.
  - dda_en in cycle T → smp_valid high from cycle T+2.
  - Minimum step period is 2 clocks; divider=0 behaves as divider=1.
- Sample handshake:
  - smp_valid stays high and smp_x/y/z stay stable until a cycle with smp_ready=1.
  - A capture in the same cycle as acceptance reloads data with smp_valid remaining 1.
- Step limit:
  - max_steps≠0 and capture makes step_count==max_steps → DONE on the same edge; no further dda_en.
  - max_steps=0: step_count wraps modulo 2^CNT_W.
- PAUSE:
  - Entered on cmd_pause from RUN: dda_en=0, divider counter=0.
  - A step already issued (cap=1) still completes its capture.
  - cmd_resume → RUN, with counter restarting from 0.
  - cmd_single issues one dda_en as soon as cap==0 and the sample port is unblocked, then remains in PAUSE. Extra cmd_single pulses while one is pending are ignored.
- DONE:
  - done=1, dda_en=0, dda_load=0; integrators hold final state.
  - The last sample stays valid until accepted.
  - Only cmd_load or cmd_start leave DONE; cmd_start restarts from initial conditions via one IDLE cycle.
- cmd_load (any state) → IDLE: smp_valid=0, cap=0, step_count=0, done=0; dda_load=1 next cycle.
- Command priority in the same cycle: cmd_load > cmd_pause > cmd_resume = cmd_single > cmd_start. Commands invalid for the current state are ignored.
- divider and max_steps are sampled live; changes take effect at the next comparison.

Test Plan:
1. Reset low then high, divider=3, max_steps=0, smp_ready=1, cmd_start → dda_en every 4 cycles; smp_valid 2 cycles after each dda_en; step_count 1,2,3…; smp_x matches integrator (x0=-1.0, dt=1/256, sigma=10 → x after step 1 = -1.0+0.1171875).
2. divider=0, smp_ready=1 → dda_en exactly every 2 cycles; never two consecutive.
3. smp_ready=0 after first sample → no second dda_en; integrator values frozen; raise smp_ready → dda_en on that cycle, next sample 2 cycles later.
4. max_steps=5, divider=1 → exactly 5 dda_en pulses; state=DONE, done=1, step_count=5; no further dda_en over 100 cycles.
5. cmd_pause mid-run then 3× cmd_single spaced 10 cycles → exactly 3 dda_en and step_count+3; cmd_resume restores periodic stepping.
6. cmd_load asserted with cmd_pause in the same cycle while smp_valid=1 → IDLE next cycle, smp_valid=0, dda_load=1, step_count=0; asynchronous reset asserted mid-RUN → all outputs at reset values immediately, without waiting for a clock edge.
